fetch_unit: RTL and testbench

//   Program-counter sequencer directly upstream of the instruction ROM/decoder.

---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program-counter sequencer feeding a combinational instruction ROM.
// Picks the next pc from the returned opcode and the execute-stage redirect.
// Also detects HALT, supports stall and restart, and counts retired instructions.
module fetch_unit #(
  parameter int          PC_W       = 16,
  parameter int          CNT_W      = 16,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [3:0]  HALT_OPC   = 4'b1110
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic [3:0]       opcode,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  logic [CNT_W-1:0] count_inc;
  assign count_inc = (&instr_count) ? instr_count : instr_count + 1'b1;

  // fetch_valid is the only output decoded straight from state.
  assign fetch_valid = (state == RUN);

  // Sequencer: state, pc, done and retired-instruction count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_ADDR;
      done        <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          pc   <= START_ADDR;
          done <= 1'b0;
          if (start) begin
            state       <= RUN;
            instr_count <= '0;
          end
        end
        RUN: begin
          // A stall freezes everything, so a HALT or redirect under stall
          // is evaluated again once the stall drops.
          if (!stall) begin
            if (opcode == HALT_OPC) begin
              // HALT retires nothing; pc keeps pointing at the HALT word.
              state <= HALTED;
              done  <= 1'b1;
            end else if (redirect) begin
              pc          <= redirect_pc;
              instr_count <= count_inc;
            end else begin
              pc          <= pc + 1'b1;
              instr_count <= count_inc;
            end
          end
        end
        HALTED: begin
          if (start) begin
            state       <= RUN;
            pc          <= START_ADDR;
            instr_count <= '0;
            done        <= 1'b0;
          end
        end
        default: begin
          // Unused encoding recovers to a clean IDLE.
          state <= IDLE;
          pc    <= START_ADDR;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit, built with a 4-bit counter so saturation is reachable.
module tb_fetch_unit;

  localparam int PC_W  = 16;
  localparam int CNT_W = 4;
  localparam logic [3:0] ADD  = 4'b0111;
  localparam logic [3:0] HALT = 4'b1110;

  logic             clk = 1'b0;
  logic             reset, start, stall, redirect;
  logic [3:0]       opcode;
  logic [PC_W-1:0]  redirect_pc;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid, done;
  logic [CNT_W-1:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W), .START_ADDR(16'h0000), .HALT_OPC(HALT)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .opcode(opcode),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc(pc),
    .fetch_valid(fetch_valid), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // One comparison: count it, report any mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [15:0] e_pc, input logic [3:0] e_cnt,
                           input logic e_fv, input logic e_done);
    check({tag, ".pc"},   32'(pc),          32'(e_pc));
    check({tag, ".cnt"},  32'(instr_count), 32'(e_cnt));
    check({tag, ".fv"},   32'(fetch_valid), 32'(e_fv));
    check({tag, ".done"}, 32'(done),        32'(e_done));
  endtask

  initial begin
    reset = 1; start = 0; stall = 0; redirect = 0; opcode = ADD; redirect_pc = '0;
    #1;
    tick(); tick();
    expect_st("reset", 16'h0000, 4'd0, 1'b0, 1'b0);

    // IDLE ignores everything but start
    reset = 0; stall = 1; redirect = 1; redirect_pc = 16'h0055; opcode = HALT;
    tick();
    expect_st("idle_ign", 16'h0000, 4'd0, 1'b0, 1'b0);

    // 1. start then five ADDs
    stall = 0; redirect = 0; opcode = ADD; start = 1;
    tick();
    start = 0;
    expect_st("t1.start", 16'h0000, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_st($sformatf("t1.step%0d", i), 16'(i), 4'(i), 1'b1, 1'b0);
    end

    // 2. redirect sequence, then HALT with redirect at pc=3
    redirect = 1; redirect_pc = 16'h0002; tick();
    expect_st("t2.rd2", 16'h0002, 4'd6, 1'b1, 1'b0);
    redirect = 0; tick();
    expect_st("t2.inc3", 16'h0003, 4'd7, 1'b1, 1'b0);
    redirect = 1; redirect_pc = 16'h0040; tick();
    expect_st("t2.rd40", 16'h0040, 4'd8, 1'b1, 1'b0);
    redirect_pc = 16'h0003; tick();
    expect_st("t2.rd3", 16'h0003, 4'd9, 1'b1, 1'b0);
    redirect_pc = 16'h0040; opcode = HALT; tick();
    expect_st("t2.halt", 16'h0003, 4'd9, 1'b0, 1'b1);
    redirect = 0; opcode = ADD; tick();
    expect_st("t2.frozen", 16'h0003, 4'd9, 1'b0, 1'b1);

    // 5. restart from HALTED, start in RUN is ignored
    start = 1; tick();
    expect_st("t5.restart", 16'h0000, 4'd0, 1'b1, 1'b0);
    tick();
    expect_st("t5.start_run", 16'h0001, 4'd1, 1'b1, 1'b0);
    start = 0; tick();
    expect_st("t5.seq", 16'h0002, 4'd2, 1'b1, 1'b0);

    // 3. stall at pc=7 holding a HALT
    for (int i = 0; i < 5; i++) tick();
    expect_st("t3.pc7", 16'h0007, 4'd7, 1'b1, 1'b0);
    stall = 1; opcode = HALT; redirect = 1; redirect_pc = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_st($sformatf("t3.stall%0d", i), 16'h0007, 4'd7, 1'b1, 1'b0);
    end
    stall = 0; tick();
    expect_st("t3.halt", 16'h0007, 4'd7, 1'b0, 1'b1);

    // 4. pc wrap and count saturation
    redirect = 0; opcode = ADD; start = 1; tick();
    start = 0;
    expect_st("t4.start", 16'h0000, 4'd0, 1'b1, 1'b0);
    redirect = 1; redirect_pc = 16'hFFFF; tick();
    expect_st("t4.ffff", 16'hFFFF, 4'd1, 1'b1, 1'b0);
    redirect = 0; tick();
    expect_st("t4.wrap", 16'h0000, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) tick();
    expect_st("t4.cnt15", 16'd13, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    expect_st("t4.sat", 16'd18, 4'hF, 1'b1, 1'b0);

    // 6. reset mid-RUN at pc=12
    opcode = HALT; tick();
    opcode = ADD; start = 1; tick();
    start = 0;
    expect_st("t6.start", 16'h0000, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    expect_st("t6.pc12", 16'd12, 4'd12, 1'b1, 1'b0);
    reset = 1; start = 1; tick();
    expect_st("t6.reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    reset = 0; tick();
    expect_st("t6.resume", 16'h0000, 4'd0, 1'b1, 1'b0);
    start = 0; tick();
    expect_st("t6.step", 16'h0001, 4'd1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
